stack_stream_reverser: RTL and testbench
========================================

// Module: stack_stream_reverser
// PURPOSE
//  Client/master for the LIFO stack: drives push/pop/w_data and consumes empty/full/r_data.
//  Accepts a valid/ready word stream, pushes each frame (s_last-terminated) into the stack,
//  then pops it out as a valid/ready stream in reversed order.
//  Sits between a stream producer and a separately instantiated stack (same B, W).
// PARAMETERS
//  B  8  data word width; must equal stack B
//  W  4  stack address bits; segment capacity CAP = 2**W-1 words
// PORTS
//  clk         in   1  clock, all logic on rising edge
//  reset       in   1  asynchronous, active-high; stack must share this reset
//  s_valid     in   1  input word valid
//  s_ready     out  1  input word accepted when s_valid & s_ready
//  s_data      in   B  input word
//  s_last      in   1  final word of input frame
//  m_valid     out  1  output word valid (registered)
//  m_ready     in   1  downstream accepts when m_valid & m_ready
//  m_data      out  B  output word (registered)
//  m_last      out  1  final word of output frame (registered)
//  stk_push    out  1  push strobe to stack
//  stk_pop     out  1  pop strobe to stack
//  stk_w_data  out  B  push data to stack (= s_data)
//  stk_empty   in   1  stack empty flag
//  stk_full    in   1  stack full flag
//  stk_r_data  in   B  stack top-of-stack word, combinational, valid when !stk_empty
// BEHAVIOUR
//  Reset: state=FILL, cnt=0, seg_last=0, m_valid=0, m_data=0, m_last=0;
//   s_ready=1 (FILL, cnt=0, !stk_full), stk_push=0, stk_pop=0.
//  cnt: W+1 bits, words in stack; +1 on push, -1 on pop, never both in one cycle.
//  FILL: s_ready = !stk_full & (cnt<CAP); stk_push = s_valid & s_ready; stk_pop=0.
//   - On push with s_last: seg_last<=1, next state DRAIN.
//   - On push making cnt==CAP without s_last: seg_last<=0, next state DRAIN (overflow split).
//  DRAIN: s_ready=0, stk_push=0.
//   - stk_pop = (cnt!=0) & (!m_valid | m_ready); on pop: m_data<=stk_r_data, m_valid<=1,
//     m_last <= seg_last & (cnt==1).
//   - If m_valid & m_ready and no pop: m_valid<=0 (m_data, m_last hold).
//   - Pop with cnt==1: next state FILL, seg_last<=0; output reg may still hold that word.
//  Latency: s_last accepted at edge E0 -> m_valid=1, m_data=that word at E1 (m_ready=1 or
//   m_valid=0). Full throughput: one word/cycle each phase with m_ready held 1.
//  Overflow split: frame longer than CAP emitted as CAP-word reversed segments, m_last=0,
//   then remainder; m_last=1 only on final word of segment holding s_last.
//  Stack flags are ignored as control except stk_full gating s_ready; cnt is authoritative.
//  Backpressure: m_valid, m_data, m_last stable while m_valid & !m_ready.
//  Reset mid-frame: partial frame discarded; stack and block both return to empty/FILL.
//  Zero-length frames impossible: each frame has >=1 word (s_last word).
// CONFIGURATION
//  REV_OVF_FLAG_EN defined: adds output port ovf (1 bit), reset 0, set sticky on the
//   edge where FILL->DRAIN occurs by overflow split; cleared only by reset.
//  REV_OVF_FLAG_EN undefined: no ovf port; all other behaviour identical.
// TESTING
//  1. Frame 0x11,0x22,0x33 (last on 0x33), m_ready=1 -> out 0x33,0x22,0x11; m_last on 0x11.
//  2. Single word 0xA5 with s_last -> m_valid at next edge, m_data=0xA5, m_last=1.
//  3. 20-word frame 0..19, W=4 -> out 14..0 (m_last=0), then 19..15 (m_last on 15);
//     ovf=1 from first split when REV_OVF_FLAG_EN defined.
//  4. Frame 1,2,3,4; m_ready toggled 1,0,0,1,... -> out 4,3,2,1 with no drops/duplicates;
//     outputs stable while stalled; stk_pop never asserted while m_valid & !m_ready.
//  5. Back-to-back frames {1,2},{3,4,5} with s_valid=1 -> out 2,1,5,4,3; s_ready=0 in DRAIN.
//  6. Reset asserted after 2 of 4 words pushed -> all outputs reset values same cycle;
//     next frame 0x7,0x8 -> out 0x8,0x7 only.

Source files
------------

// File: rtl/stack_stream_reverser_if.sv
// Valid/ready stream bundle for the stack stream reverser: input word stream (s_*)
// and reversed output stream (m_*). The reverser connects through the slave modport.
interface stack_stream_reverser_if #(
    parameter int B = 8
) ();
    logic         s_valid;
    logic         s_ready;
    logic [B-1:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [B-1:0] m_data;
    logic         m_last;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/stack_stream_reverser.sv
// Drives an external LIFO stack to emit each s_last-terminated frame in reverse order.
// Optional sticky overflow-split flag port ovf_o when REV_OVF_FLAG_EN is defined.
//
// state    | meaning
// ST_FILL  | accepting input words, pushing to stack
// ST_DRAIN | popping stack into the output register
module stack_stream_reverser #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    stack_stream_reverser_if.slave  bus,
    output logic                    stk_push_o,
    output logic                    stk_pop_o,
    output logic [B-1:0]            stk_w_data_o,
    input  logic                    stk_empty_i,
    input  logic                    stk_full_i,
    input  logic [B-1:0]            stk_r_data_i
`ifdef REV_OVF_FLAG_EN
    ,
    output logic                    ovf_o
`endif
);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;
    localparam logic [W:0] CAP      = {1'b0, {W{1'b1}}};
    localparam logic [W:0] ONE      = {{W{1'b0}}, 1'b1};

    logic [0:0]   state_q, state_d;
    logic [W:0]   cnt_q, cnt_d;
    logic         seg_last_q, seg_last_d;
    logic         m_valid_q, m_valid_d;
    logic [B-1:0] m_data_q, m_data_d;
    logic         m_last_q, m_last_d;
    logic         s_ready_c;
    logic         push_c;
    logic         pop_c;
`ifdef REV_OVF_FLAG_EN
    logic         ovf_q, ovf_d;
`endif

    // cnt_q is the authoritative occupancy; the stack empty flag is not needed
    logic         unused_stk_empty;
    assign unused_stk_empty = stk_empty_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seg_last_d = seg_last_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        s_ready_c  = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
`ifdef REV_OVF_FLAG_EN
        ovf_d      = ovf_q;
`endif

        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_FILL: begin
                s_ready_c = !stk_full_i && (cnt_q < CAP);
                push_c    = bus.s_valid && s_ready_c;
                if (push_c) begin
                    cnt_d = cnt_q + ONE;
                    if (bus.s_last) begin
                        seg_last_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end else if ((cnt_q + ONE) == CAP) begin
                        // frame longer than the stack: emit this segment unterminated
                        seg_last_d = 1'b0;
                        state_d    = ST_DRAIN;
`ifdef REV_OVF_FLAG_EN
                        ovf_d      = 1'b1;
`endif
                    end
                end
            end
            default: begin
                pop_c = (cnt_q != '0) && (!m_valid_q || bus.m_ready);
                if (pop_c) begin
                    m_data_d  = stk_r_data_i;
                    m_valid_d = 1'b1;
                    m_last_d  = seg_last_q && (cnt_q == ONE);
                    cnt_d     = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d    = ST_FILL;
                        seg_last_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            cnt_q      <= '0;
            seg_last_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_last_q <= seg_last_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
        end
    end

`ifdef REV_OVF_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign bus.s_ready  = s_ready_c;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_last   = m_last_q;
    assign stk_push_o   = push_c;
    assign stk_pop_o    = pop_c;
    assign stk_w_data_o = bus.s_data;

endmodule

// File: tb/tb_stack_stream_reverser.sv
// Bench for stack_stream_reverser with a behavioural LIFO stack and an output scoreboard.
module tb_stack_stream_reverser;
    localparam int B   = 8;
    localparam int W   = 4;
    localparam int CAP = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_stream_reverser_if #(.B(B)) bus ();

    logic         stk_push, stk_pop, stk_empty, stk_full;
    logic [B-1:0] stk_w_data, stk_r_data;
`ifdef REV_OVF_FLAG_EN
    logic         ovf;
`endif

    stack_stream_reverser #(.B(B), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .stk_push_o   (stk_push),
        .stk_pop_o    (stk_pop),
        .stk_w_data_o (stk_w_data),
        .stk_empty_i  (stk_empty),
        .stk_full_i   (stk_full),
        .stk_r_data_i (stk_r_data)
`ifdef REV_OVF_FLAG_EN
        ,
        .ovf_o        (ovf)
`endif
    );

    // behavioural stack, depth 2**W
    logic [B-1:0] mem [0:(1<<W)-1];
    logic [W:0]   sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (stk_push && sp < (W+1)'(1 << W)) begin
            mem[sp[W-1:0]] <= stk_w_data;
            sp <= sp + 1'b1;
        end else if (stk_pop && sp != '0) begin
            sp <= sp - 1'b1;
        end
    end
    assign stk_empty  = (sp == '0);
    assign stk_full   = (sp == (W+1)'(1 << W));
    assign stk_r_data = (sp != '0) ? mem[W'(sp - 1'b1)] : '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [B-1:0] d;
        logic         l;
    } exp_t;
    exp_t sb[$];

    logic [B-1:0] words[$];
    bit           lasts[$];

    task automatic run_stream(input bit stall, output logic [B-1:0] first,
                              output logic [B-1:0] final_w, output int nlast);
        int idx, n, out_n, cyc;
        bit hold;
        logic [B-1:0] hd;
        logic hl;
        logic [B-1:0] seg[$];
        exp_t e;
        idx = 0; n = words.size(); out_n = 0; cyc = 0; hold = 0; hd = '0; hl = 0;
        nlast = 0; first = '0; final_w = '0;
        while ((idx < n || out_n < n) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                chk("hold_valid", bus.m_valid, 1);
                chk("hold_data", bus.m_data, hd);
                chk("hold_last", bus.m_last, hl);
            end
            bus.s_valid = (idx < n);
            bus.s_data  = (idx < n) ? words[idx] : '0;
            bus.s_last  = (idx < n) ? lasts[idx] : 1'b0;
            bus.m_ready = stall ? ((cyc % 4) <= 1) : 1'b1;
            #1;
            chk("pop_with_s_ready", stk_pop & bus.s_ready, 0);
            chk("stack_occupancy_le_cap", (sp <= (W+1)'(CAP)), 1);
            if (bus.m_valid && !bus.m_ready) begin
                chk("pop_while_stalled", stk_pop, 0);
                hold = 1; hd = bus.m_data; hl = bus.m_last;
            end else begin
                hold = 0;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", bus.m_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", bus.m_data, e.d);
                    chk("out_last", bus.m_last, e.l);
                end
                if (out_n == 0) first = bus.m_data;
                final_w = bus.m_data;
                nlast += int'(bus.m_last);
                out_n++;
            end
            if (bus.s_valid && bus.s_ready) begin
                seg.push_back(words[idx]);
                if (lasts[idx] || seg.size() == CAP) begin
                    for (int i = seg.size() - 1; i >= 0; i--)
                        sb.push_back('{d: seg[i], l: (lasts[idx] && i == 0)});
                    seg.delete();
                end
                idx++;
            end
        end
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout actual=%0d words_out required=%0d", out_n, n);
        end
        @(negedge clk);
        bus.s_valid = 0;
        bus.s_last  = 0;
        chk("sb_drained", sb.size(), 0);
    endtask

    typedef struct {
        int           len;
        logic [B-1:0] base;
        logic [B-1:0] step;
        bit           stall;
        logic [B-1:0] exp_first;
        logic [B-1:0] exp_final;
        int           exp_nlast;
        bit           exp_ovf;
    } vec_t;
    vec_t vecs[5];

    logic [B-1:0] first, final_w;
    int nlast;

    initial begin
        vecs[0] = '{3,  8'h11, 8'h11, 1'b0, 8'h33, 8'h11, 1, 1'b0};
        vecs[1] = '{4,  8'h01, 8'h01, 1'b1, 8'h04, 8'h01, 1, 1'b0};
        vecs[2] = '{15, 8'h40, 8'h01, 1'b0, 8'h4E, 8'h40, 1, 1'b0};
        vecs[3] = '{20, 8'h00, 8'h01, 1'b0, 8'h0E, 8'h0F, 1, 1'b1};
        vecs[4] = '{16, 8'h80, 8'h01, 1'b0, 8'h8E, 8'h8F, 1, 1'b1};

        reset = 1;
        bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0; bus.m_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_stk_push", stk_push, 0);
        chk("rst_stk_pop", stk_pop, 0);
`ifdef REV_OVF_FLAG_EN
        chk("rst_ovf", ovf, 0);
`endif
        reset = 0;

        // single word: latency of one edge from s_last acceptance to m_valid
        @(negedge clk);
        bus.s_valid = 1; bus.s_data = 8'hA5; bus.s_last = 1; bus.m_ready = 1;
        #1;
        chk("single_s_ready", bus.s_ready, 1);
        chk("single_push", stk_push, 1);
        @(negedge clk);
        bus.s_valid = 0; bus.s_last = 0;
        #1;
        chk("single_valid_e0", bus.m_valid, 0);
        chk("single_pop_e0", stk_pop, 1);
        @(negedge clk);
        #1;
        chk("single_valid_e1", bus.m_valid, 1);
        chk("single_data_e1", bus.m_data, 8'hA5);
        chk("single_last_e1", bus.m_last, 1);
        @(negedge clk);
        #1;
        chk("single_valid_e2", bus.m_valid, 0);
        chk("single_stack_empty", stk_empty, 1);

        for (int v = 0; v < 5; v++) begin
            words.delete(); lasts.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                words.push_back(B'(vecs[v].base + vecs[v].step * i));
                lasts.push_back(i == vecs[v].len - 1);
            end
            run_stream(vecs[v].stall, first, final_w, nlast);
            chk($sformatf("vec%0d_first", v), first, vecs[v].exp_first);
            chk($sformatf("vec%0d_final", v), final_w, vecs[v].exp_final);
            chk($sformatf("vec%0d_nlast", v), nlast, vecs[v].exp_nlast);
`ifdef REV_OVF_FLAG_EN
            chk($sformatf("vec%0d_ovf", v), ovf, vecs[v].exp_ovf);
`endif
        end

        // back-to-back frames with s_valid held high
        words = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        lasts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        run_stream(1'b0, first, final_w, nlast);
        chk("b2b_first", first, 8'd2);
        chk("b2b_final", final_w, 8'd3);
        chk("b2b_nlast", nlast, 2);

        // reset mid-frame discards the partial frame
        @(negedge clk);
        bus.s_valid = 1; bus.s_data = 8'hC1; bus.s_last = 0; bus.m_ready = 1;
        @(negedge clk);
        bus.s_data = 8'hC2;
        @(negedge clk);
        bus.s_valid = 0;
        #1;
        chk("midframe_stack_cnt", sp, 2);
        reset = 1;
        #1;
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_m_data", bus.m_data, 0);
        chk("midrst_m_last", bus.m_last, 0);
        chk("midrst_s_ready", bus.s_ready, 1);
        chk("midrst_stk_pop", stk_pop, 0);
`ifdef REV_OVF_FLAG_EN
        chk("midrst_ovf", ovf, 0);
`endif
        @(negedge clk);
        reset = 0;
        words = '{8'h07, 8'h08};
        lasts = '{1'b0, 1'b1};
        run_stream(1'b0, first, final_w, nlast);
        chk("post_rst_first", first, 8'h08);
        chk("post_rst_final", final_w, 8'h07);
        chk("post_rst_nlast", nlast, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_idle_valid", bus.m_valid, 0);
        chk("post_rst_stack_empty", stk_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
